bus_xfer_ctrl: RTL and testbench

BUS_XFER_CTRL -- requirements
Module: bus_xfer_ctrl

---
 rtl/bus_xfer_ctrl.sv | 111 +++++++++++
 tb/tb_bus_xfer_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register transfer sequencer for a shared tristate bus.
// Each transfer enables one source, strobes one destination load, and records the bus value.
module bus_xfer_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  src,
    input  logic [2:0]  dst,
    input  logic        ext_src,
    input  logic [15:0] bus_in,
    output logic [7:0]  Tri_EN,
    output logic        Ext_Tri_EN,
    output logic [7:0]  Reg_En,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] xfer_data,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  src_q;
    logic [2:0]  dst_q;
    logic        ext_q;
    logic        done_q;
    logic        err_q;
    logic        req_ok;
    logic        req_bad;

    // Handshake: req acts as valid and !busy as ready. A request is taken only
    // on an IDLE edge; req seen while busy is dropped, never queued.
    assign req_ok  = req && (ext_src || (src != dst));
    assign req_bad = req && !ext_src && (src == dst);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_ok) state_nxt = DRIVE;
            DRIVE:   state_nxt = LATCH;
            LATCH:   state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q     <= 3'd0;
            dst_q     <= 3'd0;
            ext_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            xfer_data <= 16'd0;
        end else begin
            if (state == IDLE && req_ok) begin
                src_q <= src;
                dst_q <= dst;
                ext_q <= ext_src;
            end
            done_q <= (state == HOLD);
            err_q  <= (state == IDLE) && req_bad;
            // The destination captures on the same edge, so the recorded value matches it.
            if (state == LATCH) begin
                xfer_data <= bus_in;
            end
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    always_comb begin
        Tri_EN     = 8'd0;
        Ext_Tri_EN = 1'b0;
        Reg_En     = 8'd0;
        busy       = 1'b0;
        case (state)
            DRIVE, LATCH, HOLD: begin
                busy = 1'b1;
                if (ext_q) begin
                    Ext_Tri_EN = 1'b1;
                end else begin
                    Tri_EN[src_q] = 1'b1;
                end
                if (state == LATCH) begin
                    Reg_En = 8'd1 << dst_q;
                end
            end
            default: ;
        endcase
    end

    assign done      = done_q;
    assign err       = err_q;
    assign fsm_state = state;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench for bus_xfer_ctrl: transfer vectors with hand-computed enables,
// an expected queue of captured bus values, and continuous enable invariants.
module tb_bus_xfer_ctrl;

    logic        clk;
    logic        rst;
    logic        req;
    logic [2:0]  src;
    logic [2:0]  dst;
    logic        ext_src;
    logic [15:0] bus_in;
    logic [7:0]  Tri_EN;
    logic        Ext_Tri_EN;
    logic [7:0]  Reg_En;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] xfer_data;
    logic [1:0]  fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    bus_xfer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .src        (src),
        .dst        (dst),
        .ext_src    (ext_src),
        .bus_in     (bus_in),
        .Tri_EN     (Tri_EN),
        .Ext_Tri_EN (Ext_Tri_EN),
        .Reg_En     (Reg_En),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .xfer_data  (xfer_data),
        .fsm_state  (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer with hand-computed enable patterns.
    task automatic do_xfer(input string name, input logic [2:0] s, input logic [2:0] d,
                           input logic e, input logic [15:0] data,
                           input logic [7:0] exp_tri, input logic exp_ext, input logic [7:0] exp_reg);
        req = 1'b1; src = s; dst = d; ext_src = e; bus_in = data;
        exp_q.push_back(data);
        tick();
        req = 1'b0;
        check({name, "_drive_busy"}, busy, 1);
        check({name, "_drive_tri"}, Tri_EN, exp_tri);
        check({name, "_drive_ext"}, Ext_Tri_EN, exp_ext);
        check({name, "_drive_reg"}, Reg_En, 0);
        tick();
        check({name, "_latch_tri"}, Tri_EN, exp_tri);
        check({name, "_latch_ext"}, Ext_Tri_EN, exp_ext);
        check({name, "_latch_reg"}, Reg_En, exp_reg);
        tick();
        check({name, "_hold_tri"}, Tri_EN, exp_tri);
        check({name, "_hold_ext"}, Ext_Tri_EN, exp_ext);
        check({name, "_hold_reg"}, Reg_En, 0);
        check({name, "_hold_data"}, xfer_data, data);
        tick();
        check({name, "_done"}, done, 1);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_idle_tri"}, {Ext_Tri_EN, Tri_EN}, 0);
        tick();
        check({name, "_done_clear"}, done, 0);
    endtask

    // Scoreboard and continuous invariants, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            check("tri_onehot", $countones({Ext_Tri_EN, Tri_EN}) > 1, 0);
            check("reg_onehot", $countones(Reg_En) > 1, 0);
            check("reg_outside_latch", (Reg_En != 8'd0) && (fsm_state != 2'd2), 0);
            check("tri_in_idle", (fsm_state == 2'd0) && ({Ext_Tri_EN, Tri_EN} != 9'd0), 0);
            if (done) begin
                check("done_has_exp", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_xfer_data", xfer_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; req = 1'b0; src = 3'd0; dst = 3'd0; ext_src = 1'b0; bus_in = 16'd0;
        #2;
        check("rst_tri", Tri_EN, 0);
        check("rst_ext", Ext_Tri_EN, 0);
        check("rst_reg", Reg_En, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_data", xfer_data, 0);
        tick();
        tick();

        // First edge after release must accept a request.
        rst = 1'b1;
        req = 1'b1; src = 3'd0; dst = 3'd1; bus_in = 16'h0F0F;
        exp_q.push_back(16'h0F0F);
        tick();
        req = 1'b0;
        check("first_req_busy", busy, 1);
        check("first_req_tri", Tri_EN, 8'h01);
        tick(); tick(); tick();
        check("first_req_done", done, 1);
        tick();

        do_xfer("t_reg", 3'd2, 3'd5, 1'b0, 16'hA5C3, 8'h04, 1'b0, 8'h20);
        do_xfer("t_ext", 3'd0, 3'd0, 1'b1, 16'h1234, 8'h00, 1'b1, 8'h01);
        do_xfer("t_ext_eq", 3'd5, 3'd5, 1'b1, 16'h5A5A, 8'h00, 1'b1, 8'h20);

        // Rejected request: error pulse only.
        req = 1'b1; src = 3'd3; dst = 3'd3; ext_src = 1'b0;
        tick();
        req = 1'b0;
        check("bad_err", err, 1);
        check("bad_busy", busy, 0);
        check("bad_tri", {Ext_Tri_EN, Tri_EN}, 0);
        check("bad_reg", Reg_En, 0);
        tick();
        check("bad_err_clear", err, 0);
        check("bad_still_idle", busy, 0);

        // req held high: back-to-back 1->4, 4->1, 1->4.
        req = 1'b1; src = 3'd1; dst = 3'd4; bus_in = 16'h1111;
        exp_q.push_back(16'h1111);
        tick();
        check("b2b1_drive_tri", Tri_EN, 8'h02);
        src = 3'd4; dst = 3'd4;
        tick();
        check("b2b1_busy_no_err", err, 0);
        check("b2b1_latch_reg", Reg_En, 8'h10);
        check("b2b1_latch_tri", Tri_EN, 8'h02);
        src = 3'd4; dst = 3'd1;
        tick();
        check("b2b1_hold_data", xfer_data, 16'h1111);
        bus_in = 16'h2222;
        exp_q.push_back(16'h2222);
        tick();
        check("b2b1_done", done, 1);
        check("b2b1_idle_tri", Tri_EN, 0);
        tick();
        check("b2b2_drive_tri", Tri_EN, 8'h10);
        check("b2b2_done_clear", done, 0);
        src = 3'd1; dst = 3'd4;
        tick();
        check("b2b2_latch_reg", Reg_En, 8'h02);
        tick();
        check("b2b2_hold_data", xfer_data, 16'h2222);
        bus_in = 16'h3333;
        exp_q.push_back(16'h3333);
        tick();
        check("b2b2_done", done, 1);
        tick();
        req = 1'b0;
        check("b2b3_drive_tri", Tri_EN, 8'h02);
        tick();
        check("b2b3_latch_reg", Reg_En, 8'h10);
        tick();
        tick();
        check("b2b3_done", done, 1);
        tick();
        check("b2b3_idle_busy", busy, 0);

        // Asynchronous reset during LATCH aborts the transfer.
        req = 1'b1; src = 3'd6; dst = 3'd7; ext_src = 1'b0; bus_in = 16'hBEEF;
        tick();
        req = 1'b0;
        tick();
        check("abort_latch_reg", Reg_En, 8'h80);
        #2;
        rst = 1'b0;
        #1;
        check("abort_reg", Reg_En, 0);
        check("abort_tri", {Ext_Tri_EN, Tri_EN}, 0);
        check("abort_busy", busy, 0);
        check("abort_data", xfer_data, 0);
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_abort_done", done, 0);
            check("post_abort_reg", Reg_En, 0);
            check("post_abort_busy", busy, 0);
        end
        check("post_abort_data", xfer_data, 0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
